// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2,
    StErr  = 2'd3
  } fetch_state_e;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: imem request/response, redirect input, decode-side handshake and status.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                    imem_req_valid;
  logic [XLEN_DEFAULT-1:0] imem_req_addr;
  logic                    imem_req_ready;
  logic                    imem_resp_valid;
  logic [XLEN_DEFAULT-1:0] imem_resp_data;
  logic                    redirect_valid;
  logic [XLEN_DEFAULT-1:0] redirect_pc;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [XLEN_DEFAULT-1:0] instr;
  logic [XLEN_DEFAULT-1:0] instr_pc;
  logic                    misalign_err;
  logic [31:0]             fetch_count;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output misalign_err, fetch_count
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  misalign_err, fetch_count
  );

endinterface

// File: rtl/instr_fetch_unit_instr_hold_reg.sv
// Holds the fetched instruction word, its PC and a valid flag for decode.
module instr_fetch_unit_instr_hold_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [XLEN_DEFAULT-1:0] instr_in,
  input  logic [XLEN_DEFAULT-1:0] pc_in,
  output logic                    valid,
  output logic [XLEN_DEFAULT-1:0] instr,
  output logic [XLEN_DEFAULT-1:0] instr_pc
);

  // Clear wins over load; data is kept on clear, only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      instr_pc <= pc_in;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, holds the returned word for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            squash_q, squash_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            hold_load, hold_clear, hold_valid;
  logic [XLEN-1:0] hold_instr, hold_pc;
  logic            redirect_bad;

  assign redirect_bad = bus.redirect_valid && is_misaligned(bus.redirect_pc);

  // State register; a reset that lands mid-WAIT arms squash for the orphaned response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      squash_q      <= (state_q == StWait);
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and PC selection; redirects beat the +4 advance, misalignment beats everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;
    if (hold_valid && bus.instr_ready) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    unique case (state_q)
      StReq: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          // Request already left with the old pc; its response must be dropped.
          if (bus.imem_req_ready) begin
            squash_d = 1'b1;
            state_d  = StWait;
          end
        end else if (bus.imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_resp_valid) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_resp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            hold_load = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc;
          hold_clear = 1'b1;
          state_d    = StReq;
        end else if (bus.instr_ready) begin
          pc_d       = pc_q + XLEN'(4);
          hold_clear = 1'b1;
          state_d    = StReq;
        end
      end
      StErr: begin
      end
      default: begin
      end
    endcase
    if (redirect_bad && (state_q != StErr)) begin
      state_d    = StErr;
      pc_d       = pc_q;
      misalign_d = 1'b1;
      squash_d   = 1'b0;
      hold_load  = 1'b0;
      hold_clear = 1'b1;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.imem_req_valid = (state_q == StReq) && !rst;
    bus.imem_req_addr  = pc_q;
  end

  instr_fetch_unit_instr_hold_reg u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .instr_in (bus.imem_resp_data),
    .pc_in    (pc_q),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .instr_pc (hold_pc)
  );

  assign bus.instr_valid  = hold_valid;
  assign bus.instr        = hold_instr;
  assign bus.instr_pc     = hold_pc;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decoder and immediate generator. Drives the instruction-memory request, holds the returned 32-bit word, and presents it with its PC to decode/immediate logic over a valid/ready handshake.
- Owns the PC: sequential +4 advance, redirects from branch/jump resolution, and misaligned-target trapping.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_addr  output  32  word-aligned fetch address (= pc).
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_resp_valid  input  1  response data valid; exactly one response per accepted request, earliest next cycle.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_pc  input  32  new target PC.
- instr_valid  output  1  instr/instr_pc valid to decode.
- instr_ready  input  1  decode consumes instruction.
- instr  output  32  held instruction word.
- instr_pc  output  32  PC of held instruction.
- misalign_err  output  1  sticky: redirect target had [1:0] != 0.
- fetch_count  output  32  number of instructions delivered (instr_valid && instr_ready); wraps at 2^32.

Behaviour:
- Reset (sync, rst high at a rising edge):
  - state=REQ, pc=RESET_PC, squash=0.
  - Outputs: imem_req_valid=0 during reset; instr_valid=0, instr=0, instr_pc=0, misalign_err=0, fetch_count=0.
  - Reset mid-WAIT: the outstanding response is ignored via squash=1, set on reset if the previous state was WAIT.
- States: REQ, WAIT, HOLD, ERR.
- REQ: imem_req_valid=1, addr=pc.
  - On imem_req_ready: go to WAIT.
  - If redirect_valid occurs in the same cycle as imem_req_ready: the request leaves with the old pc; set squash=1, pc<=redirect_pc, go to WAIT.
  - If redirect_valid occurs without ready: pc<=redirect_pc and stay in REQ. The address may change while ready is low.
- WAIT: imem_req_valid=0.
  - On imem_resp_valid with squash=0: instr<=resp_data, instr_pc<=pc, instr_valid=1 next cycle, go to HOLD.
  - On imem_resp_valid with squash=1: discard data, squash<=0, go to REQ.
  - redirect_valid in WAIT: squash<=1, pc<=redirect_pc. If resp_valid arrives in the same cycle, that response is discarded and the state goes to REQ.
- HOLD: instr_valid=1; instr and instr_pc are stable until consumed.
  - On instr_ready: fetch_count+=1, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), go to REQ.
  - redirect_valid takes priority over the +4 advance, with or without instr_ready. Without instr_ready, the held instr is dropped (instr_valid=0 next cycle) and is not counted. Either way pc<=redirect_pc, go to REQ.
- Misaligned redirect (redirect_pc[1:0] != 0, any state):
  - misalign_err=1 next cycle, go to ERR.
  - Any outstanding response is ignored.
- ERR: no requests, instr_valid=0. Left only by rst.
- Latency: with a memory of ready=1 and 1-cycle response, instr_valid rises 2 cycles after REQ entry. Steady throughput is 1 instruction per 3 cycles.

Decomposition:
- Shared package: state encoding (2-bit), RESET_PC default, NOP constant 32'h0000_0013, XLEN.
- One natural sub-module: instr_hold_reg (instr/instr_pc/valid register with load, clear and sync reset).
- PC/next-PC logic and FSM stay in the top module.

Test Plan:
1. rst 3 cycles, memory ready=1 with 1-cycle response, data 32'h0050_0093, instr_ready=1 -> imem_req_addr=0 first; instr=32'h0050_0093 and instr_pc=0 with instr_valid; next request addr=4; fetch_count=1.
2. Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no new request, fetch_count unchanged; on ready -> addr advances by 4.
3. Redirect to 32'h0000_0100 in the same cycle as an accepted request at 0x8 -> response for 0x8 discarded (instr_valid never asserted for it); next request addr=0x100.
4. Redirect in HOLD without instr_ready, target 0x40 -> held instr dropped, fetch_count not incremented, next addr=0x40.
5. Redirect to 32'h0000_0102 -> misalign_err=1 next cycle, imem_req_valid stays 0; rst clears misalign_err and restarts at RESET_PC.
6. pc=32'hFFFF_FFFC, consume -> next addr=0; rst asserted during WAIT -> late response ignored, first delivered instr_pc=RESET_PC.
